// File: rtl/eth_firewall_if.sv
// Dibit stream bundle between the bit-order stage, the firewall and the byte aggregator.
// The master drives the input stream; the slave (the filter) returns the filtered stream and the verdict pulses.
interface eth_firewall_if;
  logic       axiiv;
  logic [1:0] axiid;
  logic       axiov;
  logic [1:0] axiod;
  logic       frame_pass;
  logic       frame_drop;

  modport master (output axiiv, axiid, input axiov, axiod, frame_pass, frame_drop);
  modport slave  (input axiiv, axiid, output axiov, axiod, frame_pass, frame_drop);
endinterface

// File: rtl/eth_firewall.sv
// Receive-side Ethernet filter: checks the destination MAC (unicast or broadcast) and, optionally,
// the EtherType, then strips the 14-byte header and forwards payload+FCS dibits one cycle late.
module eth_firewall #(
  parameter logic [47:0] MAC_ADDR   = 48'h69_69_5A_06_54_91,
  parameter logic [15:0] ETHERTYPE  = 16'h0800,
  parameter logic        CHECK_TYPE = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  eth_firewall_if.slave bus
);

  typedef enum logic [2:0] {IDLE, DEST, HDR, PASS, DROP, WAIT} state_t;

  localparam logic [5:0] LAST_DEST = 6'd23;
  localparam logic [5:0] TYPE_BASE = 6'd48;
  localparam logic [5:0] LAST_HDR  = 6'd55;
  localparam logic [5:0] CNT_SAT   = 6'd56;

  state_t     state, state_nxt;
  logic [5:0] cnt;
  logic       mac_ok, bc_ok, type_ok;
  logic       axiiv_q;
  logic       mac_m, bc_m, type_m;
  logic       mac_hit, type_hit;
  logic       cnt_en;

  logic       vld_p0, pass_p0, drop_p0;
  logic       vld_p1, pass_p1, drop_p1;
  logic [1:0] dout_p1;

  function automatic logic [1:0] mac_dibit(input logic [5:0] idx);
    logic [47:0] sh;
    sh = MAC_ADDR << (2 * idx);
    return sh[47:46];
  endfunction

  function automatic logic [1:0] type_dibit(input logic [5:0] idx);
    logic [15:0] sh;
    logic [5:0]  j;
    j  = idx - TYPE_BASE;
    sh = ETHERTYPE << (2 * j);
    return sh[15:14];
  endfunction

  // Per-dibit compares; the running flags plus these form the verdict on the deciding dibit
  assign mac_m    = (bus.axiid == mac_dibit(cnt));
  assign bc_m     = (bus.axiid == 2'b11);
  assign type_m   = (cnt < TYPE_BASE) || (bus.axiid == type_dibit(cnt));
  assign mac_hit  = (mac_ok & mac_m) | (bc_ok & bc_m);
  assign type_hit = !CHECK_TYPE || (type_ok & type_m);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A frame still in flight when IDLE is reached (axiiv high last cycle too) is only seen after reset
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.axiiv) state_nxt = axiiv_q ? WAIT : DEST;
      DEST: begin
        if (!bus.axiiv)             state_nxt = IDLE;
        else if (cnt == LAST_DEST)  state_nxt = mac_hit ? HDR : DROP;
      end
      HDR: begin
        if (!bus.axiiv)             state_nxt = IDLE;
        else if (cnt == LAST_HDR)   state_nxt = type_hit ? PASS : DROP;
      end
      PASS, DROP, WAIT: if (!bus.axiiv) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    vld_p0  = (state == PASS) && bus.axiiv;
    pass_p0 = (state == HDR) && bus.axiiv && (cnt == LAST_HDR) && type_hit;
    drop_p0 = ((state == DEST) && (!bus.axiiv || ((cnt == LAST_DEST) && !mac_hit))) ||
              ((state == HDR)  && (!bus.axiiv || ((cnt == LAST_HDR)  && !type_hit)));
  end

  assign cnt_en = bus.axiiv && (cnt != CNT_SAT) &&
                  ((state == DEST) || (state == HDR) || (state == PASS) ||
                   (state == DROP) || (state_nxt == DEST));

  always_ff @(posedge clk) begin
    axiiv_q <= bus.axiiv;
    if (rst) begin
      cnt     <= '0;
      mac_ok  <= 1'b0;
      bc_ok   <= 1'b0;
      type_ok <= 1'b0;
    end else begin
      if (state_nxt == IDLE) cnt <= '0;
      else if (cnt_en)       cnt <= cnt + 6'd1;
      if (state == IDLE) begin
        mac_ok  <= mac_m;
        bc_ok   <= bc_m;
        type_ok <= 1'b1;
      end else if (bus.axiiv) begin
        mac_ok  <= mac_ok & mac_m;
        bc_ok   <= bc_ok & bc_m;
        type_ok <= type_ok & type_m;
      end
    end
  end

  // Stage p0 -> p1: registered outputs, axiod holds while not forwarding
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      pass_p1 <= 1'b0;
      drop_p1 <= 1'b0;
      dout_p1 <= 2'b00;
    end else begin
      vld_p1  <= vld_p0;
      pass_p1 <= pass_p0;
      drop_p1 <= drop_p0;
      if (vld_p0) dout_p1 <= bus.axiid;
    end
  end

  assign bus.axiov      = vld_p1;
  assign bus.axiod      = dout_p1;
  assign bus.frame_pass = pass_p1;
  assign bus.frame_drop = drop_p1;

endmodule
